// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   - opcode constants used by the decode/control unit and the hazard unit
//   - shadow_entry_t: what the hazard unit remembers about an in-flight instruction
//   - br_state_t: branch-hold FSM states
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic       wr_valid;
    logic       is_load;
    logic [4:0] dest;
  } shadow_entry_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_BR_WAIT = 1'b1
  } br_state_t;

  // A read of r0 never depends on anything in flight.
  function automatic logic reg_match(input logic [4:0] r, input shadow_entry_t e);
    return (r != 5'd0) && e.wr_valid && (e.dest == r);
  endfunction

endpackage

// File: rtl/inst_reg_use.sv
// Register-usage decode for the instruction sitting in ID.
// Ports:
//   valid, opcode, rs, rt, rd : ID instruction fields
//   rd_rs_en, rd_rt_en        : instruction reads rs / rt
//   wr_valid, is_load, dest   : instruction writes dest (never r0), and is a load
module inst_reg_use
  import mips_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic       rd_rs_en,
  output logic       rd_rt_en,
  output logic       wr_valid,
  output logic       is_load,
  output logic [4:0] dest
);

  logic       wr_raw;
  logic [4:0] dest_raw;

  always_comb begin
    rd_rs_en = 1'b0;
    rd_rt_en = 1'b0;
    wr_raw   = 1'b0;
    is_load  = 1'b0;
    dest_raw = 5'd0;
    if (valid) begin
      case (opcode)
        OP_RTYPE: begin
          rd_rs_en = 1'b1;
          rd_rt_en = 1'b1;
          wr_raw   = 1'b1;
          dest_raw = rd;
        end
        OP_LW: begin
          rd_rs_en = 1'b1;
          wr_raw   = 1'b1;
          is_load  = 1'b1;
          dest_raw = rt;
        end
        OP_SW, OP_BEQ: begin
          rd_rs_en = 1'b1;
          rd_rt_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A write to r0 is architecturally discarded, so it is not a producer.
  assign wr_valid = wr_raw && (dest_raw != 5'd0);
  assign dest     = wr_valid ? dest_raw : 5'd0;

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection for the 5-stage MIPS pipeline.
// Tracks destination registers of the instructions in EX/MEM/WB, raises a
// bubble request on RAW hazards against ID, holds fetch after a BEQ issues,
// and counts stall cycles.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   id_valid, id_opcode, id_rs,
//   id_rt, id_rd                    : instruction in ID
//   hazard_detected                 : control unit must inject a bubble into EX
//   pc_write, ifid_write            : PC / IF-ID may update
//   stall_cycles                    : saturating count of hazard_detected cycles
//
// Branch FSM
//   state      | meaning
//   ST_IDLE    | normal operation, outputs follow data-hazard logic
//   ST_BR_WAIT | BEQ resolving: bubble and hold fetch, br_cnt counts down
module hazard_unit
  import mips_pkg::*;
#(
  parameter int FORWARDING     = 1,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  output logic             hazard_detected,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam bit         FWD     = (FORWARDING != 0);
  localparam logic [2:0] PEN     = 3'(BRANCH_PENALTY);
  // Stages (EX, MEM, WB) whose producers can stall ID. WB never does since the
  // register file writes in the first half of the cycle.
  localparam logic [2:0] STALL_MASK = FWD ? 3'b001 : 3'b011;
  // With forwarding only a load still in EX is too late to forward.
  localparam bit         LOAD_ONLY  = FWD;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       rd_rs_en;
  logic       rd_rt_en;
  logic       id_wr_valid;
  logic       id_is_load;
  logic [4:0] id_dest;

  inst_reg_use u_use (
    .valid    (id_valid),
    .opcode   (id_opcode),
    .rs       (id_rs),
    .rt       (id_rt),
    .rd       (id_rd),
    .rd_rs_en (rd_rs_en),
    .rd_rt_en (rd_rt_en),
    .wr_valid (id_wr_valid),
    .is_load  (id_is_load),
    .dest     (id_dest)
  );

  // sh_q[0]=EX, sh_q[1]=MEM, sh_q[2]=WB
  shadow_entry_t sh_q [3];
  shadow_entry_t ex_d;

  br_state_t   state_q;
  br_state_t   state_d;
  logic [2:0]  br_cnt_q;
  logic [2:0]  br_cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic [2:0] stage_stall;
  logic       data_haz;
  logic       beq_issue;

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      stage_stall[s] = STALL_MASK[s]
                       && ((rd_rs_en && reg_match(id_rs, sh_q[s]))
                           || (rd_rt_en && reg_match(id_rt, sh_q[s])))
                       && (!LOAD_ONLY || sh_q[s].is_load);
    end
  end

  assign data_haz  = |stage_stall;
  assign beq_issue = id_valid && (id_opcode == OP_BEQ) && !data_haz;

  always_comb begin
    state_d         = state_q;
    br_cnt_d        = br_cnt_q;
    hazard_detected = data_haz;
    pc_write        = ~data_haz;
    ifid_write      = ~data_haz;
    case (state_q)
      ST_IDLE: begin
        if (beq_issue) begin
          state_d  = ST_BR_WAIT;
          br_cnt_d = PEN;
        end
      end
      ST_BR_WAIT: begin
        hazard_detected = 1'b1;
        pc_write        = 1'b0;
        ifid_write      = 1'b0;
        br_cnt_d        = br_cnt_q - 3'd1;
        // Terminal count: this is the last hold cycle.
        if (br_cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        br_cnt_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    ex_d = '0;
    if (!hazard_detected) begin
      ex_d.wr_valid = id_wr_valid;
      ex_d.is_load  = id_is_load;
      ex_d.dest     = id_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q[0]  <= '0;
      sh_q[1]  <= '0;
      sh_q[2]  <= '0;
      state_q  <= ST_IDLE;
      br_cnt_q <= 3'd0;
      stall_q  <= '0;
    end else begin
      sh_q[2]  <= sh_q[1];
      sh_q[1]  <= sh_q[0];
      sh_q[0]  <= ex_d;
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
      if (hazard_detected && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_q;

endmodule
